sum_serial_ctrl: RTL and testbench
==================================

// Module: sum_serial_ctrl
// PURPOSE
//   Bit-serial adder controller. Sequences a single 1-bit full-adder cell
//   (sum = a^b^c, cout = a&b | c&(a^b)) across W-bit operands, LSB first,
//   using a start/busy/done handshake. Used where one full-adder slice is
//   shared over time instead of building a W-bit ripple adder.
// PARAMETERS
//   W   8   Operand width in bits; legal range W >= 1.
// PORTS
//   clk     in   1   Single clock; all state updates on the rising edge.
//   rst_n   in   1   Asynchronous, active-low reset.
//   start   in   1   Request an addition; sampled only in IDLE.
//   in_a    in   W   Operand A; captured on the accepting edge.
//   in_b    in   W   Operand B; captured on the accepting edge.
//   cin     in   1   Carry-in; captured on the accepting edge.
//   busy    out  1   High while the serial addition runs (RUN state).
//   done    out  1   One-cycle pulse: sum/cout hold a new result.
//   sum     out  W   Registered result; stable between updates.
//   cout    out  1   Registered carry-out of bit W-1.
// BEHAVIOUR
//   - Reset (rst_n=0, async): state=IDLE. busy=0, done=0, sum=0, cout=0.
//     Shift registers, carry flop and bit counter are cleared.
//   - FSM: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE: start=1 at edge E0 is the accepting edge. On E0:
//     in_a/in_b go to shift regs, cin to the carry flop, counter=0, next=RUN.
//     start=0 keeps the FSM in IDLE.
//   - RUN: busy=1. Each edge feeds bit 0 of each shift reg and the carry
//     flop into the FA cell. The FA sum bit shifts into the MSB of the
//     working sum reg. The carry flop takes the FA cout. Operand regs shift
//     right. The counter increments.
//   - RUN ends on the edge that processes bit W-1 (counter==W-1), which is
//     edge E0+W. On that edge: sum <= completed working reg, cout <= final
//     FA cout, next=DONE.
//   - DONE: done=1 and busy=0 for exactly one cycle, then next=IDLE on the
//     following edge. The earliest new accepting edge is E0+W+2.
//   - Latency: busy is high for exactly W cycles after E0. done is high in
//     the cycle that follows edge E0+W.
//   - start in RUN or DONE: ignored. No queuing, no operand update.
//   - in_a/in_b/cin after E0: ignored until the next accepting edge.
//   - sum/cout change only on the RUN->DONE edge. They hold the last result
//     through IDLE and the whole next RUN.
//   - Arithmetic: {cout,sum} == in_a + in_b + cin, modulo 2^(W+1), exactly.
//     The W-bit sum wraps and the overflow appears only on cout.
//   - Counter width is $clog2(W+1). It never passes W-1. W=1 is legal and
//     runs a single RUN cycle.
//   - Reset during RUN or DONE: abort immediately. No done pulse, and
//     sum/cout return to 0.
//   - done and busy are never high in the same cycle.
// TESTING
//   1. W=8: start, A=0x5A, B=0x3C, cin=0 -> busy 8 cycles, then done pulse;
//      sum=0x96, cout=0.
//   2. W=8: A=0xFF, B=0x01, cin=0 -> sum=0x00, cout=1 (wrap).
//      A=0xFF, B=0xFF, cin=1 -> sum=0xFF, cout=1.
//   3. W=8: during RUN of A=0x01, B=0x02, hold start=1 with A=0xF0 ->
//      result stays 0x03/cout 0 with one done pulse only. A new op is
//      accepted only after DONE returns to IDLE.
//   4. W=8: rst_n=0 at the 4th RUN cycle -> busy=0, done=0, sum=0, cout=0
//      asynchronously. No done pulse follows. A fresh start works.
//   5. W=1: all 8 {in_a,in_b,cin} combos -> {cout,sum} = 00,01,01,10,01,10,
//      10,11. Each done pulse comes 2 cycles after the accepting edge.
//   6. W=8: 200 random ops with start held high -> each op matches
//      a+b+cin. Accepting edges are spaced exactly W+2 cycles apart.

Source files
------------

// File: rtl/sum_serial_ctrl.sv
// Bit-serial adder controller.
// One full-adder cell is reused over W clock cycles, LSB first, to form
// {cout, sum} = in_a + in_b + cin. A start/busy/done handshake frames each
// operation: IDLE accepts a request, RUN walks the bits, DONE pulses once.
module sum_serial_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Bit counter only has to reach W-1; one extra code keeps W=1 legal.
  localparam int              CW   = $clog2(W + 1);
  localparam logic [CW-1:0]   LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [W-1:0]  op_a;        // operand A, shifted right once per RUN cycle
  logic [W-1:0]  op_b;        // operand B, shifted right once per RUN cycle
  logic          carry;       // carry flop between successive bit slices
  logic [W-1:0]  work;        // partial sum, filled from the MSB side
  logic [CW-1:0] cnt;         // index of the bit being processed

  logic          fa_sum;
  logic          fa_cout;
  logic [W-1:0]  work_shift;
  logic          accept;
  logic          last;

  // The shared full-adder slice and the next value of the working sum.
  always_comb begin
    fa_sum     = op_a[0] ^ op_b[0] ^ carry;
    fa_cout    = (op_a[0] & op_b[0]) | (carry & (op_a[0] ^ op_b[0]));
    // Shifting {fa_sum, work} right drops the new bit into the MSB; this
    // form also holds for W=1, where work[W-1:1] would be an empty slice.
    work_shift = W'({fa_sum, work} >> 1);
  end

  assign accept = (state == S_IDLE) && start;
  assign last   = (cnt == LAST);

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE; start is ignored outside IDLE.
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_RUN;
      S_RUN:   if (last)  state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand capture on the accepting edge, then one bit slice per RUN cycle.
  // NOTE: every datapath register is in the async reset so an aborted
  // operation leaves no stale operand, carry or count behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      work  <= '0;
      cnt   <= '0;
    end else if (accept) begin
      op_a  <= in_a;
      op_b  <= in_b;
      carry <= cin;
      work  <= '0;
      cnt   <= '0;
    end else if (state == S_RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      carry <= fa_cout;
      work  <= work_shift;
      // The counter parks on W-1 rather than wrapping past it.
      if (!last) cnt <= cnt + CW'(1);
    end
  end

  // Result registers: updated only on the final RUN edge, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if ((state == S_RUN) && last) begin
      sum  <= work_shift;
      cout <= fa_cout;
    end
  end

  // Handshake outputs decode straight from the state register, so busy and
  // done are glitch-free and mutually exclusive.
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_sum_serial_ctrl.sv
// Self-checking bench for sum_serial_ctrl: a W=8 instance and a W=1 instance,
// table-driven vectors, hand-written abort/hold sequences, random chained ops.
// Expected results go into a per-instance queue when an operation is accepted
// and are popped when that instance raises done.
module tb_sum_serial_ctrl;

  localparam int W8 = 8;

  logic          clk;
  logic          rst_n;

  logic          start8, cin8, busy8, done8, cout8;
  logic [W8-1:0] a8, b8, sum8;

  logic          start1, cin1, busy1, done1, cout1;
  logic [0:0]    a1, b1, sum1;

  int vectors     = 0;
  int miscompares = 0;
  int done8_cnt   = 0;

  logic [W8:0] q8[$];
  logic [1:0]  q1[$];
  logic [W8:0] last8 = '0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  typedef struct {
    logic       a;
    logic       b;
    logic       c;
    logic [1:0] exp;
  } vec1_t;

  vec8_t tbl8[6];
  vec1_t tbl1[8];

  sum_serial_ctrl #(.W(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_a(a8), .in_b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  sum_serial_ctrl #(.W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_a(a1), .in_b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitors: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_overlap8", busy8 & done8, 1'b0);
      if (done8) begin
        done8_cnt++;
        check("done8_has_pending_op", q8.size() != 0, 1'b1);
        if (q8.size() != 0) begin
          last8 = q8.pop_front();
          check("result8", {cout8, sum8}, last8);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy_done_overlap1", busy1 & done1, 1'b0);
      if (done1) begin
        check("done1_has_pending_op", q1.size() != 0, 1'b1);
        if (q1.size() != 0) check("result1", {cout1, sum1}, q1.pop_front());
      end
    end
  end

  // One W=8 operation, cycle by cycle from the accepting edge to the return
  // to IDLE. hold keeps start high throughout; rnd scrambles the operands
  // after acceptance (otherwise hold drives a fixed distractor operand set).
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp, input bit hold, input bit rnd);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(posedge clk); #1;
    check("accept_busy8", busy8, 1'b1);
    q8.push_back(exp);
    for (int i = 1; i <= W8 + 1; i++) begin
      @(negedge clk);
      start8 = hold;
      if (rnd) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end else if (hold) begin
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1;
      end
      @(posedge clk); #1;
      check("busy8_phase", busy8, (i < W8));
      check("done8_phase", done8, (i == W8));
      if (i < W8) check("sum8_held_in_run", {cout8, sum8}, last8);
    end
  endtask

  // One W=1 operation: a single RUN cycle, done in the following cycle.
  task automatic op1(input logic a, input logic b, input logic c, input logic [1:0] exp);
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    @(posedge clk); #1;
    check("accept_busy1", busy1, 1'b1);
    q1.push_back(exp);
    @(negedge clk);
    start1 = 1'b0;
    @(posedge clk); #1;
    check("busy1_after_run", busy1, 1'b0);
    check("done1_after_run", done1, 1'b1);
    @(posedge clk); #1;
    check("done1_one_cycle", done1, 1'b0);
    check("busy1_idle", busy1, 1'b0);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rc;
    int         d0;

    tbl8[0] = '{a: 8'h5A, b: 8'h3C, c: 1'b0, s: 8'h96, co: 1'b0};
    tbl8[1] = '{a: 8'hFF, b: 8'h01, c: 1'b0, s: 8'h00, co: 1'b1};
    tbl8[2] = '{a: 8'h80, b: 8'h80, c: 1'b0, s: 8'h00, co: 1'b1};
    tbl8[3] = '{a: 8'h00, b: 8'h00, c: 1'b1, s: 8'h01, co: 1'b0};
    tbl8[4] = '{a: 8'h12, b: 8'h34, c: 1'b1, s: 8'h47, co: 1'b0};
    tbl8[5] = '{a: 8'hFF, b: 8'hFF, c: 1'b1, s: 8'hFF, co: 1'b1};

    tbl1[0] = '{a: 1'b0, b: 1'b0, c: 1'b0, exp: 2'b00};
    tbl1[1] = '{a: 1'b0, b: 1'b0, c: 1'b1, exp: 2'b01};
    tbl1[2] = '{a: 1'b0, b: 1'b1, c: 1'b0, exp: 2'b01};
    tbl1[3] = '{a: 1'b0, b: 1'b1, c: 1'b1, exp: 2'b10};
    tbl1[4] = '{a: 1'b1, b: 1'b0, c: 1'b0, exp: 2'b01};
    tbl1[5] = '{a: 1'b1, b: 1'b0, c: 1'b1, exp: 2'b10};
    tbl1[6] = '{a: 1'b1, b: 1'b1, c: 1'b0, exp: 2'b10};
    tbl1[7] = '{a: 1'b1, b: 1'b1, c: 1'b1, exp: 2'b11};

    rst_n  = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", busy8, 1'b0);
    check("rst_done8", done8, 1'b0);
    check("rst_result8", {cout8, sum8}, 9'h000);
    check("rst_busy1", busy1, 1'b0);
    check("rst_result1", {cout1, sum1}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Start held low: the FSM must stay in IDLE.
    repeat (3) @(posedge clk);
    #1;
    check("idle_without_start", busy8, 1'b0);

    // Directed W=8 vectors including wrap and all-ones cases.
    for (int i = 0; i < 6; i++)
      op8(tbl8[i].a, tbl8[i].b, tbl8[i].c, {tbl8[i].co, tbl8[i].s}, 1'b0, 1'b0);

    // start held high during RUN/DONE with different operands: one result only.
    d0 = done8_cnt;
    op8(8'h01, 8'h02, 1'b0, 9'h003, 1'b1, 1'b0);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("single_done_with_start_held", done8_cnt - d0, 1);
    check("result_kept_after_hold", {cout8, sum8}, 9'h003);
    check("no_requeue_busy", busy8, 1'b0);

    // Load a non-zero result so the abort clearing it is observable.
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0, 1'b0);

    // Async reset in the 4th RUN cycle: abort with no done pulse.
    d0 = done8_cnt;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    check("abort_result", {cout8, sum8}, 9'h000);
    last8 = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W8 + 3) @(negedge clk);
    check("no_done_after_abort", done8_cnt - d0, 0);
    check("idle_after_abort", busy8, 1'b0);
    op8(8'h5A, 8'h3C, 1'b0, 9'h096, 1'b0, 1'b0);

    // W=1: all eight input combinations.
    for (int i = 0; i < 8; i++) op1(tbl1[i].a, tbl1[i].b, tbl1[i].c, tbl1[i].exp);

    // 200 back-to-back random ops with start held high: accepting edges are
    // W+2 apart, which op8 verifies through busy at every edge.
    for (int k = 0; k < 200; k++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      op8(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'h00, rc}, 1'b1, 1'b1);
    end
    @(negedge clk);
    start8 = 1'b0;

    repeat (4) @(negedge clk);
    check("queue8_drained", q8.size(), 0);
    check("queue1_drained", q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
